// File: rtl/des_decrypt_iter_pkg.sv
// Shared DES constants: permutation and S-box tables, decrypt rotate schedule,
// FSM state encoding and fixed-width permutation helpers (bit 1 = MSB).
package des_decrypt_iter_pkg;

  localparam int BLK_W    = 64;
  localparam int HALF_W   = 32;
  localparam int CD_W     = 28;
  localparam int SUBKEY_W = 48;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Right-rotate amounts that walk C/D backwards from C16/D16 (= C0/D0).
  localparam int RSHIFT [16] = '{1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1, 0};

  // Indexed by {row, col}, row = {b6, b1}, col = b5..b2 of each 6-bit group.
  localparam int SBOX [8][64] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
      0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
      4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
      15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
      3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
      0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
      13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
      1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
      13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
      3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
      14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
      4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
      11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
      10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
      9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
      4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
      13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
      1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
      6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
      1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
      7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
      2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

  function automatic logic [63:0] des_ip(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] des_fp(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
    return y;
  endfunction

  function automatic logic [55:0] des_pc1(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] des_pc2(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] des_e(input logic [31:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[47-i] = x[32-E_T[i]];
    return y;
  endfunction

  function automatic logic [31:0] des_p(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int i = 0; i < 32; i++) y[31-i] = x[32-P_T[i]];
    return y;
  endfunction

endpackage

// File: rtl/des_f_function.sv
// DES round function F(R, K) = P(S(E(R) ^ K)).
module des_f_function
  import des_decrypt_iter_pkg::*;
(
  input  logic [HALF_W-1:0]   r,
  input  logic [SUBKEY_W-1:0] subkey,
  output logic [HALF_W-1:0]   f
);

  logic [SUBKEY_W-1:0] mixed;
  logic [HALF_W-1:0]   sbox_out;

  assign mixed = des_e(r) ^ subkey;

  sbox_layer u_sbox (
    .x(mixed),
    .y(sbox_out)
  );

  assign f = des_p(sbox_out);

endmodule

// File: rtl/des_key_sched_dec.sv
// Decrypt key schedule: holds C/D, presents PC2 subkey, rotates right per round.
module des_key_sched_dec
  import des_decrypt_iter_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                step,
  input  logic [BLK_W-1:0]    key,
  input  logic [3:0]          round,
  output logic [SUBKEY_W-1:0] subkey
);

  logic [CD_W-1:0] c;
  logic [CD_W-1:0] d;

  always_ff @(posedge clk) begin
    if (rst) begin
      c <= '0;
      d <= '0;
    end else if (load) begin
      {c, d} <= des_pc1(key);
    end else if (step) begin
      if (RSHIFT[round] == 2) begin
        c <= {c[1:0], c[CD_W-1:2]};
        d <= {d[1:0], d[CD_W-1:2]};
      end else if (RSHIFT[round] == 1) begin
        c <= {c[0], c[CD_W-1:1]};
        d <= {d[0], d[CD_W-1:1]};
      end
    end
  end

  assign subkey = des_pc2({c, d});

endmodule

// File: rtl/sbox_layer.sv
// DES S-box layer: eight 6-to-4 substitutions over a 48-bit word.
module sbox_layer
  import des_decrypt_iter_pkg::*;
(
  input  logic [47:0] x,
  output logic [31:0] y
);

  for (genvar s = 0; s < 8; s++) begin : g_sbox
    logic [5:0] b;
    assign b = x[47-6*s -: 6];
    assign y[31-4*s -: 4] = 4'(SBOX[s][{b[5], b[0], b[4:1]}]);
  end

endmodule

// File: rtl/des_decrypt_iter.sv
// Iterative DES decryption core, one Feistel round per clock.
// Optional CBC chaining (iv_load/iv ports) is built when DES_CBC_EN is defined.
module des_decrypt_iter
  import des_decrypt_iter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
  input  logic [BLK_W-1:0] in_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             busy
`ifdef DES_CBC_EN
  ,
  input  logic             iv_load,
  input  logic [BLK_W-1:0] iv
`endif
);

  // state    | meaning
  // ST_IDLE  | waiting for a ciphertext/key, in_ready high
  // ST_ROUND | one Feistel round per clock, round = 0..15
  // ST_DONE  | plaintext held on out_data until out_ready

  state_t state, state_nxt;

  logic [3:0]          round;
  logic [HALF_W-1:0]   l, r, f_out, r_nxt;
  logic [SUBKEY_W-1:0] subkey;
  logic [BLK_W-1:0]    pt_raw, pt_mask;
  logic                accept, round_step, out_hs;

  assign accept     = in_valid && in_ready;
  assign round_step = (state == ST_ROUND);
  assign out_hs     = (state == ST_DONE) && out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = ST_ROUND;
      end
      ST_ROUND: if (round == 4'd15) state_nxt = ST_DONE;
      ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
      default: begin
        state_nxt = ST_IDLE;
        busy      = 1'b0;
      end
    endcase
  end

  des_key_sched_dec u_key_sched (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .step  (round_step),
    .key   (in_key),
    .round (round),
    .subkey(subkey)
  );

  des_f_function u_f (
    .r     (r),
    .subkey(subkey),
    .f     (f_out)
  );

  assign r_nxt  = l ^ f_out;
  // Final swap: output is FP({R16, L16}) where L16 is the current R.
  assign pt_raw = des_fp({r_nxt, r});

`ifdef DES_CBC_EN
  logic [BLK_W-1:0] chain;
  logic [BLK_W-1:0] ct_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain   <= '0;
      ct_hold <= '0;
    end else begin
      if (state == ST_IDLE && iv_load) chain <= iv;
      else if (out_hs)                 chain <= ct_hold;
      if (accept) ct_hold <= in_data;
    end
  end

  assign pt_mask = chain;
`else
  assign pt_mask = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      round     <= '0;
      l         <= '0;
      r         <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            {l, r} <= des_ip(in_data);
            round  <= '0;
          end
        end
        ST_ROUND: begin
          l <= r;
          r <= r_nxt;
          if (round == 4'd15) begin
            out_data  <= pt_raw ^ pt_mask;
            out_valid <= 1'b1;
          end else begin
            round <= round + 4'd1;
          end
        end
        ST_DONE: if (out_hs) out_valid <= 1'b0;
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Self-checking bench for des_decrypt_iter: known answers, backpressure,
// mid-round reset, random loopback and (with DES_CBC_EN) CBC chaining.
module tb_des_decrypt_iter;
  import des_decrypt_iter_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [63:0] in_data, in_key, out_data;
`ifdef DES_CBC_EN
  logic        iv_load;
  logic [63:0] iv;
`endif

  int          checks = 0;
  int          failures = 0;
  logic [63:0] chain_m, cur_ct;

  always #5 clk = ~clk;

  des_decrypt_iter dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_key   (in_key),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
`ifdef DES_CBC_EN
    ,
    .iv_load  (iv_load),
    .iv       (iv)
`endif
  );

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model: plain forward DES ----------------
  function automatic int tab(input int sel, input int i);
    case (sel)
      0:       return IP_T[i];
      1:       return FP_T[i];
      2:       return PC1_T[i];
      3:       return PC2_T[i];
      4:       return E_T[i];
      default: return P_T[i];
    endcase
  endfunction

  function automatic logic [63:0] perm(input logic [63:0] x, input int nin,
                                       input int nout, input int sel);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < nout; i++) y[nout-1-i] = x[nin-tab(sel, i)];
    return y;
  endfunction

  function automatic logic [31:0] m_f(input logic [31:0] rr, input logic [47:0] k);
    logic [63:0] t;
    logic [47:0] x;
    logic [31:0] s_out;
    logic [5:0]  b;
    int          row, col;
    t = perm({32'd0, rr}, 32, 48, 4);
    x = t[47:0] ^ k;
    s_out = '0;
    for (int s = 0; s < 8; s++) begin
      b = x[47-6*s -: 6];
      row = int'({b[5], b[0]});
      col = int'(b[4:1]);
      s_out = {s_out[27:0], 4'(SBOX[s][row*16+col])};
    end
    t = perm({32'd0, s_out}, 32, 32, 5);
    return t[31:0];
  endfunction

  function automatic logic [63:0] m_encrypt(input logic [63:0] key, input logic [63:0] pt);
    int          lsh [16];
    logic [63:0] t64;
    logic [27:0] c, d;
    logic [47:0] ks [16];
    logic [31:0] l, rr, tmp;
    lsh = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    t64 = perm(key, 64, 56, 2);
    c = t64[55:28];
    d = t64[27:0];
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < lsh[i]; j++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      t64 = perm({8'd0, c, d}, 56, 48, 3);
      ks[i] = t64[47:0];
    end
    t64 = perm(pt, 64, 64, 0);
    l = t64[63:32];
    rr = t64[31:0];
    for (int i = 0; i < 16; i++) begin
      tmp = rr;
      rr = l ^ m_f(rr, ks[i]);
      l = tmp;
    end
    return perm({rr, l}, 64, 64, 1);
  endfunction

  // ---------------- checking and stimulus helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Called at a negedge while idle; the following posedge accepts.
  task automatic send(input logic [63:0] key, input logic [63:0] ct);
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data  = ct;
    in_key   = key;
    cur_ct   = ct;
  endtask

  // Accepting cycle is cycle 0; plaintext must first show in cycle 17.
  task automatic collect(input logic [63:0] exp, input int hold, input logic nxt_en,
                         input logic [63:0] nxt_key, input logic [63:0] nxt_ct);
    int cyc;
    cyc = 41;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        in_valid = nxt_en;
        in_data  = nxt_en ? nxt_ct : rnd64();
        in_key   = nxt_en ? nxt_key : rnd64();
      end
      if (k == 8) begin
        chk("busy_mid", 64'(busy), 64'd1);
        chk("in_ready_mid", 64'(in_ready), 64'd0);
      end
`ifdef DES_CBC_EN
      iv_load = (k == 5);
      iv      = rnd64();
`endif
      if (out_valid) begin
        cyc = k;
        break;
      end
    end
`ifdef DES_CBC_EN
    iv_load = 1'b0;
`endif
    chk("latency", 64'(cyc), 64'd17);
    chk("out_data", out_data, exp);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_data", out_data, exp);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hs_valid", 64'(out_valid), 64'd0);
    chk("hs_data_kept", out_data, exp);
    chk("hs_in_ready", 64'(in_ready), 64'd1);
    chk("hs_busy", 64'(busy), 64'd0);
`ifdef DES_CBC_EN
    chain_m = cur_ct;
`endif
    if (nxt_en) cur_ct = nxt_ct;
  endtask

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] C1 = 64'h85E813540F0AB405;
  localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] P2 = 64'h8787878787878787;

  initial begin
    logic [63:0] key, pt, ct, ivv, p1, p2, c1, c2;
    int          stray;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_key = '0; out_ready = 1'b0;
    chain_m = '0; cur_ct = '0;
`ifdef DES_CBC_EN
    iv_load = 1'b0; iv = '0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Known answers, including a key with every parity bit flipped.
    send(K1, C1);
    collect(P1 ^ chain_m, 0, 1'b0, '0, '0);
    send(K2, 64'd0);
    collect(P2 ^ chain_m, 0, 1'b0, '0, '0);
    send(K2 ^ 64'h0101010101010101, 64'd0);
    collect(P2 ^ chain_m, 0, 1'b0, '0, '0);

    // Backpressure with a second block waiting on in_valid throughout.
    send(K1, C1);
    collect(P1 ^ chain_m, 5, 1'b1, K2, 64'd0);
    collect(P2 ^ chain_m, 0, 1'b0, '0, '0);

    // Reset during round 7 discards the block.
    key = rnd64(); pt = rnd64(); ct = m_encrypt(key, pt);
    send(key, ct);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chain_m = '0;
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_in_ready", 64'(in_ready), 64'd1);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_out_data", out_data, 64'd0);
    stray = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    chk("mrst_no_partial", 64'(stray), 64'd0);
    key = rnd64(); pt = rnd64(); ct = m_encrypt(key, pt);
    send(key, ct);
    collect(pt ^ chain_m, 0, 1'b0, '0, '0);

`ifdef DES_CBC_EN
    // IV loaded in the same cycle as the first block; mid-round pulses ignored.
    key = rnd64(); p1 = rnd64(); p2 = rnd64();
    ivv = 64'h0123456789ABCDEF;
    c1 = m_encrypt(key, p1 ^ ivv);
    c2 = m_encrypt(key, p2 ^ c1);
    iv_load = 1'b1;
    iv = ivv;
    send(key, c1);
    chain_m = ivv;
    collect(p1, 0, 1'b0, '0, '0);
    send(key, c2);
    collect(p2, 1, 1'b0, '0, '0);
`else
    p1 = '0; p2 = '0; c1 = '0; c2 = '0; ivv = '0;
`endif

    // Loopback of random plaintexts through the reference encryptor.
    for (int i = 0; i < 100; i++) begin
      key = rnd64(); pt = rnd64(); ct = m_encrypt(key, pt);
      send(key, ct);
      collect(pt ^ chain_m, int'($urandom_range(0, 2)), 1'b0, '0, '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
